// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the two-port data-memory arbiter.
package dmem_pkg;
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_RESP  = 2'd2;

  // The RAM cannot split an access across two words.
  function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] a);
    return (size == SZ_WORD && a != 2'b00) || (size == SZ_HALF && a == 2'b11);
  endfunction

  function automatic logic illegal_acc(input logic [1:0] size, input logic [1:0] a);
    return (size == SZ_NONE) || crosses_word(size, a);
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and RAM-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic [1:0]        size0, size1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic              err0, err1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] dw_data;
  logic [1:0]        dw_size;
  logic [DATA_W-1:0] d_data;

  modport slave (
    input  req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1, d_data,
    output gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata, d_addr, dw_data, dw_size
  );

  modport master (
    output req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1, d_data,
    input  gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata, d_addr, dw_data, dw_size
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way picker: round-robin, or port 0 wins ties when FIXED_PRIO is set.
module rr_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic       o_any,
  output logic       o_win
);
  logic r_ptr;  // port preferred on a tie
  logic w_win;

  always_comb begin
    w_win = 1'b0;
    case (i_req)
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = (FIXED_PRIO != 0) ? 1'b0 : r_ptr;
      default: w_win = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn)                r_ptr <= 1'b0;
    else if (i_adv && o_any)   r_ptr <= ~w_win;
  end

  assign o_any = |i_req;
  assign o_win = w_win;
endmodule

// File: rtl/dmem_arbiter.sv
// Serialises two requesters onto the single RAM data port; one access per two cycles.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic           clk,
  input  logic           resetn,
  dmem_arbiter_if.slave  io_bus
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_d_addr;
  logic [DATA_W-1:0] r_dw_data;
  logic [1:0]        r_dw_size;
  logic              r_port;
  logic              r_ill;
  logic [1:0]        r_gnt;
  logic [1:0]        r_rvalid;
  logic [1:0]        r_err;

  logic              w_can_arb, w_any, w_win, w_we, w_ill;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  assign w_can_arb = (r_state == ST_IDLE) || (r_state == ST_RESP);

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk    (clk),
    .resetn (resetn),
    .i_req  ({io_bus.req1, io_bus.req0}),
    .i_adv  (w_can_arb),
    .o_any  (w_any),
    .o_win  (w_win)
  );

  assign w_we    = w_win ? io_bus.we1    : io_bus.we0;
  assign w_size  = w_win ? io_bus.size1  : io_bus.size0;
  assign w_addr  = w_win ? io_bus.addr1  : io_bus.addr0;
  assign w_wdata = w_win ? io_bus.wdata1 : io_bus.wdata0;
  assign w_ill   = illegal_acc(w_size, w_addr[1:0]);

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state   <= ST_IDLE;
      r_d_addr  <= '0;
      r_dw_data <= '0;
      r_dw_size <= SZ_NONE;
      r_port    <= 1'b0;
      r_ill     <= 1'b0;
      r_gnt     <= '0;
      r_rvalid  <= '0;
      r_err     <= '0;
    end else begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_err    <= '0;
      case (r_state)
        ST_ISSUE: begin
          r_state          <= ST_RESP;
          r_dw_size        <= SZ_NONE;
          r_rvalid[r_port] <= 1'b1;
          r_err[r_port]    <= r_ill;
        end
        default: begin
          if (w_any) begin
            r_state      <= ST_ISSUE;
            r_d_addr     <= w_addr;
            r_dw_data    <= w_wdata;
            r_dw_size    <= (w_we && !w_ill) ? w_size : SZ_NONE;
            r_port       <= w_win;
            r_ill        <= w_ill;
            r_gnt[w_win] <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign io_bus.gnt0    = r_gnt[0];
  assign io_bus.gnt1    = r_gnt[1];
  assign io_bus.rvalid0 = r_rvalid[0];
  assign io_bus.rvalid1 = r_rvalid[1];
  assign io_bus.err0    = r_err[0];
  assign io_bus.err1    = r_err[1];
  assign io_bus.rdata   = io_bus.d_data;
  assign io_bus.d_addr  = r_d_addr;
  assign io_bus.dw_data = r_dw_data;
  // Reset masks the write strobe at once so a store caught in ISSUE never reaches the RAM.
  assign io_bus.dw_size = resetn ? SZ_NONE : r_dw_size;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed RAM model behind it.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic resetn;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus ();
  dmem_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus_f ();

  dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .resetn(resetn), .io_bus(bus));
  dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .FIXED_PRIO(1)) dut_f (
    .clk(clk), .resetn(resetn), .io_bus(bus_f));

  assign bus_f.d_data = '0;

  logic [7:0] mem [0:16383];

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (k < nbytes(bus.dw_size)) mem[bus.d_addr + 14'(k)] <= bus.dw_data[8*k +: 8];
    bus.d_data <= {mem[{bus.d_addr[13:2], 2'd3}], mem[{bus.d_addr[13:2], 2'd2}],
                   mem[{bus.d_addr[13:2], 2'd1}], mem[{bus.d_addr[13:2], 2'd0}]}
                  >> (8 * bus.d_addr[1:0]);
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [1:0]  size;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [1:0]  exp_dws;
    bit          exp_err;
    logic [31:0] mask;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input bit p, input bit req, input bit we, input logic [1:0] size,
                          input logic [13:0] addr, input logic [31:0] wdata);
    if (p) begin
      bus.req1 = req; bus.we1 = we; bus.size1 = size; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = req; bus.we0 = we; bus.size0 = size; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  function automatic vec_t mk(bit p, bit we, logic [1:0] sz, logic [13:0] a, logic [31:0] wd,
                              logic [1:0] dws, bit e, logic [31:0] m, logic [31:0] rd);
    vec_t v;
    v.port = p; v.we = we; v.size = sz; v.addr = a; v.wdata = wd;
    v.exp_dws = dws; v.exp_err = e; v.mask = m; v.exp_rd = rd;
    return v;
  endfunction

  function automatic logic g_of(bit p);
    return p ? bus.gnt1 : bus.gnt0;
  endfunction
  function automatic logic v_of(bit p);
    return p ? bus.rvalid1 : bus.rvalid0;
  endfunction
  function automatic logic e_of(bit p);
    return p ? bus.err1 : bus.err0;
  endfunction

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
  end

  initial begin
    //          port we  size   addr     wdata        dws    err mask          rdata
    vt[0]  = mk(0, 1, 2'b11, 14'h0100, 32'hDEADBEEF, 2'b11, 0, 32'h0,        32'h0);
    vt[1]  = mk(0, 0, 2'b11, 14'h0100, 32'h0,        2'b00, 0, 32'hFFFFFFFF, 32'hDEADBEEF);
    vt[2]  = mk(0, 1, 2'b11, 14'h0200, 32'h00000000, 2'b11, 0, 32'h0,        32'h0);
    vt[3]  = mk(1, 1, 2'b01, 14'h0203, 32'h000000AA, 2'b01, 0, 32'h0,        32'h0);
    vt[4]  = mk(0, 1, 2'b10, 14'h0200, 32'h00001234, 2'b10, 0, 32'h0,        32'h0);
    vt[5]  = mk(1, 0, 2'b11, 14'h0200, 32'h0,        2'b00, 0, 32'hFFFFFFFF, 32'hAA001234);
    vt[6]  = mk(0, 0, 2'b01, 14'h0203, 32'h0,        2'b00, 0, 32'h000000FF, 32'h000000AA);
    vt[7]  = mk(0, 1, 2'b11, 14'h0100, 32'h11223344, 2'b11, 0, 32'h0,        32'h0);
    vt[8]  = mk(0, 1, 2'b11, 14'h0102, 32'h55667788, 2'b00, 1, 32'h0,        32'h0);
    vt[9]  = mk(0, 0, 2'b11, 14'h0100, 32'h0,        2'b00, 0, 32'hFFFFFFFF, 32'h11223344);
    vt[10] = mk(1, 1, 2'b10, 14'h0103, 32'h00009999, 2'b00, 1, 32'h0,        32'h0);
    vt[11] = mk(0, 1, 2'b00, 14'h0100, 32'hFFFFFFFF, 2'b00, 1, 32'h0,        32'h0);
    vt[12] = mk(1, 0, 2'b11, 14'h0100, 32'h0,        2'b00, 0, 32'hFFFFFFFF, 32'h11223344);
    vt[13] = mk(0, 0, 2'b10, 14'h0102, 32'h0,        2'b00, 0, 32'h0000FFFF, 32'h00001122);
    vt[14] = mk(1, 0, 2'b11, 14'h0101, 32'h0,        2'b00, 1, 32'h0,        32'h0);
    vt[15] = mk(1, 0, 2'b10, 14'h0101, 32'h0,        2'b00, 0, 32'h0000FFFF, 32'h00002233);

    resetn = 1'b1;
    set_port(0, 0, 0, 2'b00, 14'h0, 32'h0);
    set_port(1, 0, 0, 2'b00, 14'h0, 32'h0);
    bus_f.req0 = 0; bus_f.req1 = 0; bus_f.we0 = 0; bus_f.we1 = 0;
    bus_f.size0 = 2'b11; bus_f.size1 = 2'b11; bus_f.addr0 = '0; bus_f.addr1 = '0;
    bus_f.wdata0 = '0; bus_f.wdata1 = '0;
    step(); step();

    chk("rst_gnt",    {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    chk("rst_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    chk("rst_err",    {30'd0, bus.err1, bus.err0}, 32'd0);
    chk("rst_dwsize", {30'd0, bus.dw_size}, 32'd0);
    chk("rst_daddr",  {18'd0, bus.d_addr}, 32'd0);
    chk("rst_dwdata", bus.dw_data, 32'd0);

    // reset and request together: reset wins
    set_port(0, 1, 1, 2'b11, 14'h0400, 32'h00000BAD);
    step();
    chk("rst_req_nognt", {31'd0, bus.gnt0}, 32'd0);
    set_port(0, 0, 0, 2'b00, 14'h0, 32'h0);
    resetn = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      set_port(vt[i].port, 1, vt[i].we, vt[i].size, vt[i].addr, vt[i].wdata);
      step();
      chk($sformatf("v%0d_gnt", i),    {31'd0, g_of(vt[i].port)}, 32'd1);
      chk($sformatf("v%0d_gnt_oth", i), {31'd0, g_of(!vt[i].port)}, 32'd0);
      chk($sformatf("v%0d_dwsize", i), {30'd0, bus.dw_size}, {30'd0, vt[i].exp_dws});
      chk($sformatf("v%0d_daddr", i),  {18'd0, bus.d_addr}, {18'd0, vt[i].addr});
      set_port(vt[i].port, 0, 0, 2'b00, 14'h0, 32'h0);
      step();
      chk($sformatf("v%0d_rvalid", i), {31'd0, v_of(vt[i].port)}, 32'd1);
      chk($sformatf("v%0d_err", i),    {31'd0, e_of(vt[i].port)}, {31'd0, vt[i].exp_err});
      chk($sformatf("v%0d_dwsize_off", i), {30'd0, bus.dw_size}, 32'd0);
      if (vt[i].mask != 0)
        chk($sformatf("v%0d_rdata", i), bus.rdata & vt[i].mask, vt[i].exp_rd);
      step();
    end

    // contention: both ports hold req; pointer freshly reset
    resetn = 1'b1; step(); resetn = 1'b0;
    set_port(0, 1, 0, 2'b11, 14'h0100, 32'h0);
    set_port(1, 1, 0, 2'b11, 14'h0200, 32'h0);
    bus_f.req0 = 1; bus_f.req1 = 1;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk($sformatf("rr_c%0d_gnt", c), {30'd0, bus.gnt1, bus.gnt0},
          (c % 4 == 1) ? 32'd1 : (c % 4 == 3) ? 32'd2 : 32'd0);
      chk($sformatf("fp_c%0d_gnt", c), {30'd0, bus_f.gnt1, bus_f.gnt0},
          (c % 2 == 1) ? 32'd1 : 32'd0);
    end
    set_port(0, 0, 0, 2'b00, 14'h0, 32'h0);
    set_port(1, 0, 0, 2'b00, 14'h0, 32'h0);
    bus_f.req0 = 0; bus_f.req1 = 0;
    step(); step(); step();

    // reset during ISSUE of a port-0 store
    set_port(0, 1, 1, 2'b11, 14'h0300, 32'hCAFEF00D);
    step();
    chk("mid_gnt0", {31'd0, bus.gnt0}, 32'd1);
    chk("mid_dwsize_pre", {30'd0, bus.dw_size}, 32'd3);
    set_port(0, 0, 0, 2'b00, 14'h0, 32'h0);
    resetn = 1'b1;
    #1;
    chk("mid_dwsize_rst", {30'd0, bus.dw_size}, 32'd0);
    step();
    resetn = 1'b0;
    chk("mid_norvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    chk("mid_dwsize", {30'd0, bus.dw_size}, 32'd0);
    set_port(0, 1, 0, 2'b11, 14'h0300, 32'h0);
    set_port(1, 1, 0, 2'b11, 14'h0300, 32'h0);
    step();
    chk("mid_first_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
    set_port(0, 0, 0, 2'b00, 14'h0, 32'h0);
    step();
    chk("mid_rvalid0", {31'd0, bus.rvalid0}, 32'd1);
    chk("mid_mem_kept", bus.rdata, 32'h0);
    step();
    chk("mid_second_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
    set_port(1, 0, 0, 2'b00, 14'h0, 32'h0);
    step();
    chk("mid_rvalid1", {31'd0, bus.rvalid1}, 32'd1);
    step();

    // back-to-back: port 1 raises req while port 0 is in ISSUE
    set_port(0, 1, 0, 2'b11, 14'h0100, 32'h0);
    step();
    chk("b2b_gnt0", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
    set_port(0, 0, 0, 2'b00, 14'h0, 32'h0);
    set_port(1, 1, 0, 2'b11, 14'h0200, 32'h0);
    step();
    chk("b2b_rvalid0", {31'd0, bus.rvalid0}, 32'd1);
    chk("b2b_rdata0", bus.rdata, 32'h11223344);
    chk("b2b_gnt_resp", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    step();
    chk("b2b_gnt1", {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
    set_port(1, 0, 0, 2'b00, 14'h0, 32'h0);
    step();
    chk("b2b_rvalid1", {31'd0, bus.rvalid1}, 32'd1);
    chk("b2b_rdata1", bus.rdata, 32'hAA001234);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data port of the 16 KB unified RAM between two requesters.
- Port 0 is the core load/store unit. Port 1 is a host/debug loader that fills or inspects memory.
- Serialises accesses, drives the RAM write port for exactly one cycle per store, returns read data with a fixed latency, and rejects accesses that would cross a word boundary (the RAM cannot split them).
- Sits between the requesters and the RAM's d_addr/dw_data/dw_size/d_data pins.

Parameters:
- ADDR_W, 14, byte address width of the RAM data port
- DATA_W, 32, data width
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins ties

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-high reset (name kept from the core's convention)
- req0, req1  in  1  request; held high until the matching gnt pulse
- we0, we1  in  1  1 = store, 0 = load
- size0, size1  in  2  01 = byte, 10 = half, 11 = word; 00 is illegal
- addr0, addr1  in  ADDR_W  byte address
- wdata0, wdata1  in  DATA_W  store data, right-aligned
- gnt0, gnt1  out  1  one-cycle accept pulse
- rvalid0, rvalid1  out  1  one-cycle completion pulse, for loads and stores
- err0, err1  out  1  qualifies rvalid: access rejected
- rdata  out  DATA_W  shared response data = d_data passthrough; valid only while an rvalid is high and the access was a load
- d_addr  out  ADDR_W  RAM data address (registered)
- dw_data  out  DATA_W  RAM write data (registered)
- dw_size  out  2  RAM write size (registered); 00 = no write
- d_data  in  DATA_W  RAM read data, registered inside the RAM, shifted right by addr[1:0]

Behaviour:
- FSM states: IDLE, ISSUE, RESP.
- Reset (any state):
  - state goes to IDLE.
  - gnt, rvalid, err, dw_size are all 0. d_addr and dw_data are 0.
  - Round-robin pointer prefers port 0.
  - An in-flight transaction is dropped: no rvalid, no write.
- Arbitration happens in IDLE and in RESP.
  - If exactly one req is high, that port wins.
  - If both are high, FIXED_PRIO=1 picks port 0. Otherwise the port not granted last wins, and the pointer flips on every grant.
- Grant edge (IDLE/RESP to ISSUE):
  - Register d_addr = addr of the winner.
  - Register dw_data = wdata of the winner.
  - Register dw_size = size if (we && legal), else 00.
  - Latch port id, we and illegal flag.
  - gnt of the winner is high for the following cycle (ISSUE).
- Illegal access: size==00; size==11 with addr[1:0]!=0; size==10 with addr[1:0]==11.
- ISSUE to RESP is unconditional.
  - On that edge the RAM captures d_addr and performs any write.
  - dw_size returns to 00, so each store is exactly one cycle.
  - rvalid/err of the latched port are set for the RESP cycle.
- RESP:
  - rdata = d_data.
  - If a req is pending, grant it (back to ISSUE); else go to IDLE.
- Latency:
  - req seen in IDLE at cycle T: gnt at T+1, rvalid at T+2.
  - Sustained throughput: one access per 2 cycles.
- Requesters must drop req in the cycle after gnt. A req still high in RESP is treated as a new request.
- Illegal load: rvalid+err; RAM is addressed but rdata is ignored. Illegal store: rvalid+err, RAM is not written.
- Simultaneous reset and req: reset wins; no gnt on the following cycle.
- Port inputs are sampled only on the grant edge. Changes at any other time have no effect.

Decomposition:
- Shared package `dmem_pkg`:
  - size encodings SZ_NONE/SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state enum
  - `crosses_word(size, addr[1:0])` function
- Sub-module `rr_arb2`: 2-way round-robin/fixed-priority picker with pointer register, FIXED_PRIO parameter, advance-on-grant input. The rest stays flat.

Test Plan:
- Single word store then load on port 0: store 0xDEADBEEF @0x0100, then load word @0x0100.
  - gnt0 at T+1; dw_size=11 for one cycle only.
  - Load rvalid0 at T+2 of the load, rdata=0xDEADBEEF, err0=0.
- Byte/half stores: byte 0xAA @0x0203 and half 0x1234 @0x0200 over word 0x0.
  - Word load @0x0200 returns 0xAA001234. Byte load @0x0203 returns rdata[7:0]=0xAA.
- Contention round-robin: req0 and req1 held continuously with FIXED_PRIO=0.
  - Grants alternate 0,1,0,1 every 2 cycles.
  - With FIXED_PRIO=1, port 0 wins every time port 1 contends.
- Illegal accesses: word store @0x0102 with prior content 0x11223344.
  - rvalid0=1, err0=1, dw_size stays 00, word still 0x11223344.
  - Same for half @0x0103 and size=00.
- Reset mid-operation: assert resetn during ISSUE of a store.
  - No rvalid, dw_size=00, memory unchanged.
  - Next simultaneous req0/req1 grants port 0 first.
- Back-to-back from RESP: req1 raised while port 0 is in ISSUE.
  - gnt1 appears in the cycle after rvalid0, with no IDLE cycle in between.
